// File: rtl/multiport_ram_pkg.sv
// Shared types and constants for the multiport RAM: FSM states and the
// read-during-write policy selectors.
package multiport_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/multiport_ram_wr_arb.sv
// Same-address write arbitration: the lowest-index port wins, and any higher port
// hitting the same address is dropped. Purely combinational, with no backpressure.
module multiport_ram_wr_arb #(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 9
) (
    input  logic [NPORTS-1:0]        write_en,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    output logic [NPORTS-1:0]        grant,
    output logic [NPORTS-1:0]        drop
);

    always_comb begin
        drop = '0;
        for (int i = 1; i < NPORTS; i++) begin
            for (int j = 0; j < i; j++) begin
                if (write_en[i] && write_en[j] &&
                    addr[i*ADDR_W +: ADDR_W] == addr[j*ADDR_W +: ADDR_W]) begin
                    drop[i] = 1'b1;
                end
            end
        end
        grant = write_en & ~drop;
    end

endmodule

// File: rtl/multiport_ram.sv
// N-port RAM that zeroes itself after reset and then has a 1-cycle registered read.
// Ports are ignored until ready; colliding writes go to the lowest port and the losers are flagged.
module multiport_ram
    import multiport_ram_pkg::*;
#(
    parameter int NPORTS   = 4,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int RDW_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        write_en,
    input  logic [NPORTS-1:0]        read_en,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] Data_in,
    output logic [NPORTS*DATA_W-1:0] Data_out,
    output logic [NPORTS-1:0]        rd_valid,
    output logic [NPORTS-1:0]        wr_conflict,
    output logic                     ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int SWEEP = DEPTH / NPORTS;
    localparam int CNT_W = (SWEEP > 1) ? $clog2(SWEEP) : 1;

    if ((DEPTH % NPORTS) != 0) begin : g_depth_check
        $error("multiport_ram: DEPTH must be a multiple of NPORTS");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                run;
    logic [NPORTS-1:0]   wr_vld, grant, drop;
    logic [DATA_W-1:0]   rd_dat [NPORTS];

    assign run    = (state_q == ST_RUN);
    assign ready  = run;
    assign wr_vld = write_en & {NPORTS{run}};

    multiport_ram_wr_arb #(
        .NPORTS (NPORTS),
        .ADDR_W (ADDR_W)
    ) u_wr_arb (
        .write_en (wr_vld),
        .addr     (addr),
        .grant    (grant),
        .drop     (drop)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == CNT_W'(SWEEP - 1)) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                cnt_q <= (state_d == ST_RUN) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Sweep clears one group of NPORTS words per cycle; the RUN writes use arbitrated grants.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                for (int p = 0; p < NPORTS; p++) begin
                    mem[ADDR_W'(int'(cnt_q) * NPORTS + p)] <= '0;
                end
            end else begin
                for (int i = 0; i < NPORTS; i++) begin
                    if (grant[i]) begin
                        mem[addr[i*ADDR_W +: ADDR_W]] <= Data_in[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Granted writes are address-unique, so at most one of them can forward to a given read.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            rd_dat[i] = mem[addr[i*ADDR_W +: ADDR_W]];
            if (RDW_MODE == RDW_NEW) begin
                for (int j = 0; j < NPORTS; j++) begin
                    if (grant[j] && addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W]) begin
                        rd_dat[i] = Data_in[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Data_out    <= '0;
            rd_valid    <= '0;
            wr_conflict <= '0;
        end else begin
            rd_valid    <= read_en & {NPORTS{run}};
            wr_conflict <= drop;
            for (int i = 0; i < NPORTS; i++) begin
                if (run && read_en[i]) begin
                    Data_out[i*DATA_W +: DATA_W] <= rd_dat[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_ram.sv
// Directed bench for multiport_ram: two instances share stimulus and differ only
// in the read-during-write policy.
module tb_multiport_ram;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int AW = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     write_en, read_en;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  din;
    logic [NP*DW-1:0]  dout1, dout0;
    logic [NP-1:0]     rd_valid1, rd_valid0, wr_conflict1, wr_conflict0;
    logic              ready1, ready0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multiport_ram #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1)) dut_new (
        .clk (clk), .rst (rst), .write_en (write_en), .read_en (read_en),
        .addr (addr), .Data_in (din), .Data_out (dout1), .rd_valid (rd_valid1),
        .wr_conflict (wr_conflict1), .ready (ready1)
    );

    multiport_ram #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0)) dut_old (
        .clk (clk), .rst (rst), .write_en (write_en), .read_en (read_en),
        .addr (addr), .Data_in (din), .Data_out (dout0), .rd_valid (rd_valid0),
        .wr_conflict (wr_conflict0), .ready (ready0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        write_en = '0;
        read_en  = '0;
        addr     = '0;
        din      = '0;
    endtask

    task automatic set_port(input int p, input logic we, input logic re,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en[p]       = we;
        read_en[p]        = re;
        addr[p*AW +: AW]  = a;
        din[p*DW +: DW]   = d;
    endtask

    function automatic logic [DW-1:0] out1(input int p);
        return dout1[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] out0(input int p);
        return dout0[p*DW +: DW];
    endfunction

    // Called just after the edge that sampled rst=1; counts edges until ready.
    task automatic wait_ready(input string tag);
        int n = 0;
        rst = 1'b0;
        while (!ready1 && n < 300) begin
            step();
            n++;
        end
        check(tag, n, 128);
        check({tag, "_old"}, {31'd0, ready0}, 32'd1);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step();
        check("rst_ready", {31'd0, ready1}, 32'd0);
        check("rst_rd_valid", {28'd0, rd_valid1}, 32'd0);
        check("rst_wr_conflict", {28'd0, wr_conflict1}, 32'd0);
        check("rst_dout", dout1[31:0], 32'd0);
        wait_ready("init_cycles");

        // Freshly swept memory reads as zero at both ends and the middle
        set_port(0, 1'b0, 1'b1, 9'd0, '0);
        set_port(1, 1'b0, 1'b1, 9'd255, '0);
        set_port(2, 1'b0, 1'b1, 9'd511, '0);
        step();
        clr();
        check("init_rd0", out1(0), 0);
        check("init_rd255", out1(1), 0);
        check("init_rd511", out1(2), 0);
        check("init_rd_valid", {28'd0, rd_valid1}, 32'h7);

        // Parallel writes to distinct addresses, then read back on all ports
        set_port(0, 1'b1, 1'b0, 9'd1, 16'd1);
        set_port(1, 1'b1, 1'b0, 9'd4, 16'd7);
        set_port(2, 1'b1, 1'b0, 9'd7, 16'd15);
        set_port(3, 1'b1, 1'b0, 9'd10, 16'd70);
        step();
        check("par_no_conflict", {28'd0, wr_conflict1}, 32'd0);
        check("par_no_rd_valid", {28'd0, rd_valid1}, 32'd0);
        write_en = '0;
        read_en  = '1;
        step();
        clr();
        check("par_rd_p0", out1(0), 1);
        check("par_rd_p1", out1(1), 7);
        check("par_rd_p2", out1(2), 15);
        check("par_rd_p3", out1(3), 70);
        check("par_rd_valid", {28'd0, rd_valid1}, 32'hF);
        step();
        check("rd_valid_pulse", {28'd0, rd_valid1}, 32'd0);

        // Two ports collide on one address: port 1 wins, port 3 is dropped
        set_port(1, 1'b1, 1'b0, 9'd5, 16'd9);
        set_port(3, 1'b1, 1'b0, 9'd5, 16'd50);
        step();
        clr();
        check("conflict_vec", {28'd0, wr_conflict1}, 32'h8);
        check("conflict_vec_old", {28'd0, wr_conflict0}, 32'h8);
        step();
        check("conflict_pulse", {28'd0, wr_conflict1}, 32'd0);
        set_port(0, 1'b0, 1'b1, 9'd5, '0);
        step();
        clr();
        check("conflict_winner", out1(0), 9);

        // Read-during-write on address 8 (old value 4, new value 35)
        set_port(1, 1'b1, 1'b0, 9'd8, 16'd4);
        step();
        clr();
        set_port(0, 1'b1, 1'b0, 9'd8, 16'd35);
        set_port(2, 1'b0, 1'b1, 9'd8, '0);
        step();
        clr();
        check("rdw_new", out1(2), 35);
        check("rdw_old", out0(2), 4);
        check("rdw_valid_old", {28'd0, rd_valid0}, 32'h4);

        // All ports read the same address together
        read_en = '1;
        for (int p = 0; p < NP; p++) addr[p*AW +: AW] = 9'd8;
        step();
        clr();
        for (int p = 0; p < NP; p++) check($sformatf("multi_rd_p%0d", p), out1(p), 35);

        // Hold: Data_out keeps its value while read_en is low, even if memory changes
        set_port(0, 1'b1, 1'b0, 9'd3, 16'd8);
        step();
        clr();
        set_port(0, 1'b0, 1'b1, 9'd3, '0);
        step();
        clr();
        check("hold_first", out1(0), 8);
        for (int k = 0; k < 5; k++) begin
            set_port(0, 1'b0, 1'b0, 9'd3, '0);
            set_port(1, 1'b1, 1'b0, 9'd3, 16'd99);
            step();
            clr();
            check($sformatf("hold_dout_%0d", k), out1(0), 8);
            check($sformatf("hold_valid_%0d", k), {31'd0, rd_valid1[0]}, 32'd0);
        end

        // Reset from RUN, then again mid-sweep; traffic during INIT must be ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_port(0, 1'b1, 1'b1, 9'd1, 16'h55);
        set_port(1, 1'b1, 1'b1, 9'd1, 16'h66);
        read_en = '1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (k == 30) begin
                check("init_rd_valid_low", {28'd0, rd_valid1}, 32'd0);
                check("init_conflict_low", {28'd0, wr_conflict1}, 32'd0);
                check("init_ready_low", {31'd0, ready1}, 32'd0);
            end
        end
        rst = 1'b1;
        step();
        clr();
        wait_ready("resweep_cycles");

        read_en = '1;
        addr = {9'd10, 9'd7, 9'd4, 9'd1};
        step();
        clr();
        check("lost_a1", out1(0), 0);
        check("lost_a4", out1(1), 0);
        check("lost_a7", out1(2), 0);
        check("lost_a10", out1(3), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
